// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the ALU: accepts one decoded MIPS instruction, drives the ALU for one cycle, returns a writeback/branch response.
// Latency: accept at edge N, EXEC in cycle N+1, rsp_valid_o from cycle N+2; minimum issue interval 3 cycles.
// Backpressure: instr_ready_o is high only in IDLE; the response is held in RESP until rsp_ready_i.
//
// Ports:
//   clk_i, rst_i                   clock and async active-low reset
//   instr_valid_i / instr_ready_o  instruction handshake (instr_i, pc_i, rs_data_i, rt_data_i)
//   alu_src1_o, alu_src2_o, alu_ctrl_o  ALU drive, valid only in EXEC
//   alu_result_i, alu_zero_i       combinational ALU return, captured at the end of EXEC
//   rsp_valid_o / rsp_ready_i      response handshake (wb_*, branch_*, illegal_o)
module alu_issue_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_valid_i,
   output logic        instr_ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] rs_data_i,
   input  logic [31:0] rt_data_i,
   output logic [31:0] alu_src1_o,
   output logic [31:0] alu_src2_o,
   output logic [3:0]  alu_ctrl_o,
   input  logic [31:0] alu_result_i,
   input  logic        alu_zero_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic        wb_we_o,
   output logic [4:0]  wb_reg_o,
   output logic [31:0] wb_data_o,
   output logic        branch_o,
   output logic        branch_taken_o,
   output logic [31:0] branch_target_o,
   output logic        illegal_o
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [4:0]  wb_reg;
      logic        wb_we;
      logic        branch;
      logic        illegal;
      logic [31:0] target;
   } dec_t;

   state_t state_q, state_d;
   logic   accept;
   dec_t   dec_d, dec_q;
   logic [31:0] result_q;
   logic        zero_q;

   // Instruction fields
   logic [5:0]  opcode;
   logic [4:0]  rt_f, rd_f, shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [31:0] imm_sext, imm_zext;
   logic        wr_en;
   logic        unused_rs_field;

   assign opcode   = instr_i[31:26];
   assign rt_f     = instr_i[20:16];
   assign rd_f     = instr_i[15:11];
   assign shamt    = instr_i[10:6];
   assign funct    = instr_i[5:0];
   assign imm      = instr_i[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0000, imm};
   // Register numbers are resolved upstream; only the operand data arrive here.
   assign unused_rs_field = &{1'b0, instr_i[25:21]};

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      instr_ready_o = 1'b0;
      rsp_valid_o   = 1'b0;
      accept        = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready_o = 1'b1;
            if (instr_valid_i) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: state_d = RESP;
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- Decode ----------------
   always_comb begin
      dec_d         = '0;
      wr_en         = 1'b0;
      dec_d.src1    = rs_data_i;
      dec_d.src2    = rt_data_i;
      dec_d.wb_reg  = rt_f;
      // Offset is sign-extended to 32 bits, then shifted; the sum wraps.
      dec_d.target  = pc_i + 32'd4 + {imm_sext[29:0], 2'b00};
      case (opcode)
         6'h00: begin
            dec_d.wb_reg = rd_f;
            wr_en        = 1'b1;
            case (funct)
               6'h24: dec_d.ctrl = 4'b0000;
               6'h25: dec_d.ctrl = 4'b0001;
               6'h20: dec_d.ctrl = 4'b0010;
               6'h22: dec_d.ctrl = 4'b0110;
               6'h2A: dec_d.ctrl = 4'b0111;
               6'h03: begin
                  dec_d.ctrl = 4'b1000;
                  dec_d.src1 = {27'd0, shamt};
               end
               6'h07: dec_d.ctrl = 4'b1001;
               default: begin
                  dec_d.illegal = 1'b1;
                  wr_en         = 1'b0;
               end
            endcase
         end
         6'h08: begin dec_d.ctrl = 4'b0010; dec_d.src2 = imm_sext; wr_en = 1'b1; end
         6'h0A: begin dec_d.ctrl = 4'b0111; dec_d.src2 = imm_sext; wr_en = 1'b1; end
         6'h0D: begin dec_d.ctrl = 4'b0001; dec_d.src2 = imm_zext; wr_en = 1'b1; end
         6'h0F: begin dec_d.ctrl = 4'b0101; dec_d.src2 = imm_zext; wr_en = 1'b1; end
         6'h04: begin dec_d.ctrl = 4'b0011; dec_d.branch = 1'b1; end
         6'h05: begin dec_d.ctrl = 4'b0100; dec_d.branch = 1'b1; end
         default: dec_d.illegal = 1'b1;
      endcase
      // Writes to r0 are discarded.
      dec_d.wb_we = wr_en & (dec_d.wb_reg != 5'd0);
   end

   // ---------------- Datapath registers ----------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         dec_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         if (accept) dec_q <= dec_d;
         if (state_q == EXEC) begin
            result_q <= alu_result_i;
            zero_q   <= alu_zero_i;
         end
      end
   end

   assign alu_ctrl_o      = dec_q.ctrl;
   assign alu_src1_o      = dec_q.src1;
   assign alu_src2_o      = dec_q.src2;
   assign wb_we_o         = dec_q.wb_we;
   assign wb_reg_o        = dec_q.wb_reg;
   assign wb_data_o       = result_q;
   assign branch_o        = dec_q.branch;
   // The ALU encodings for BEQ/BNE make zero=1 exactly when the branch is taken.
   assign branch_taken_o  = zero_q;
   assign branch_target_o = dec_q.target;
   assign illegal_o       = dec_q.illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_valid_i;
   logic        instr_ready_o;
   logic [31:0] instr_i, pc_i, rs_data_i, rt_data_i;
   logic [31:0] alu_src1_o, alu_src2_o;
   logic [3:0]  alu_ctrl_o;
   logic [31:0] alu_result_i;
   logic        alu_zero_i;
   logic        rsp_valid_o, rsp_ready_i;
   logic        wb_we_o;
   logic [4:0]  wb_reg_o;
   logic [31:0] wb_data_o;
   logic        branch_o, branch_taken_o;
   logic [31:0] branch_target_o;
   logic        illegal_o;

   int total = 0;
   int bad   = 0;

   alu_issue_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
      .instr_i(instr_i), .pc_i(pc_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
      .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
      .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .wb_we_o(wb_we_o), .wb_reg_o(wb_reg_o), .wb_data_o(wb_data_o),
      .branch_o(branch_o), .branch_taken_o(branch_taken_o),
      .branch_target_o(branch_target_o), .illegal_o(illegal_o)
   );

   always #5 clk_i = ~clk_i;

   // Environment ALU: combinational, encodings as seen by the sequencer.
   always_comb begin
      alu_result_i = 32'h0;
      case (alu_ctrl_o)
         4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
         4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
         4'b0010: alu_result_i = alu_src1_o + alu_src2_o;
         4'b0011: alu_result_i = alu_src1_o - alu_src2_o;
         4'b0100: alu_result_i = (alu_src1_o == alu_src2_o) ? 32'd1 : 32'd0;
         4'b0101: alu_result_i = alu_src2_o << 16;
         4'b0110: alu_result_i = alu_src1_o - alu_src2_o;
         4'b0111: alu_result_i = ($signed(alu_src1_o) < $signed(alu_src2_o)) ? 32'd1 : 32'd0;
         4'b1000: alu_result_i = $signed(alu_src2_o) >>> alu_src1_o[4:0];
         4'b1001: alu_result_i = $signed(alu_src2_o) >>> alu_src1_o[4:0];
         default: alu_result_i = 32'h0;
      endcase
   end
   assign alu_zero_i = (alu_result_i == 32'h0);

   function automatic logic [31:0] rtype(input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn);
      return {6'h00, 5'd1, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [15:0] im);
      return {op, 5'd1, rt, im};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Presents one instruction in IDLE; returns 1ns after the accepting edge (EXEC).
   task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt);
      check("ready_before_send", {31'd0, instr_ready_o}, 32'd1);
      instr_i       = ins;
      pc_i          = pc;
      rs_data_i     = rs;
      rt_data_i     = rt;
      instr_valid_i = 1'b1;
      step();
      instr_valid_i = 1'b0;
   endtask

   initial begin
      rst_i         = 1'b0;
      instr_valid_i = 1'b0;
      rsp_ready_i   = 1'b1;
      instr_i       = '0;
      pc_i          = '0;
      rs_data_i     = '0;
      rt_data_i     = '0;

      // ---- Reset state ----
      step(); step();
      check("rst_ready", {31'd0, instr_ready_o}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      check("rst_alu_ctrl", {28'd0, alu_ctrl_o}, 32'd0);
      check("rst_wb_data", wb_data_o, 32'd0);
      rst_i = 1'b1;
      step();

      // ---- Reset mid-EXEC of an ADD ----
      send(rtype(5'd2, 5'd3, 5'd0, 6'h20), 32'h0, 32'h7FFFFFFF, 32'h1);
      check("rstx_exec_ctrl", {28'd0, alu_ctrl_o}, 32'h2);
      rst_i = 1'b0;
      #1;
      check("rstx_ctrl", {28'd0, alu_ctrl_o}, 32'd0);
      check("rstx_src1", alu_src1_o, 32'd0);
      check("rstx_src2", alu_src2_o, 32'd0);
      check("rstx_flags", {25'd0, rsp_valid_o, wb_we_o, wb_reg_o != 5'd0, branch_o,
                           branch_taken_o, illegal_o, 1'b0}, 32'd0);
      check("rstx_target", branch_target_o, 32'd0);
      check("rstx_ready", {31'd0, instr_ready_o}, 32'd1);
      step();
      rst_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rstx_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      end

      // ---- ADD with overflow wrap ----
      send(rtype(5'd2, 5'd3, 5'd0, 6'h20), 32'h0, 32'h7FFFFFFF, 32'h1);
      check("add_ctrl", {28'd0, alu_ctrl_o}, 32'h2);
      check("add_src1", alu_src1_o, 32'h7FFFFFFF);
      check("add_src2", alu_src2_o, 32'h1);
      check("add_exec_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      check("add_exec_ready", {31'd0, instr_ready_o}, 32'd0);
      step();
      check("add_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("add_wb_data", wb_data_o, 32'h80000000);
      check("add_wb_reg", {27'd0, wb_reg_o}, 32'd3);
      check("add_wb_we", {31'd0, wb_we_o}, 32'd1);
      check("add_branch", {31'd0, branch_o}, 32'd0);
      check("add_illegal", {31'd0, illegal_o}, 32'd0);
      step();
      check("add_done_valid", {31'd0, rsp_valid_o}, 32'd0);

      // ---- SRA ----
      send(rtype(5'd2, 5'd5, 5'd4, 6'h03), 32'h0, 32'h12345678, 32'hF0000000);
      check("sra_src1", alu_src1_o, 32'd4);
      check("sra_ctrl", {28'd0, alu_ctrl_o}, 32'h8);
      step();
      check("sra_wb_data", wb_data_o, 32'hFF000000);
      check("sra_wb_reg", {27'd0, wb_reg_o}, 32'd5);
      step();

      // ---- SLTI, imm sign-extended ----
      send(itype(6'h0A, 5'd6, 16'hFFFF), 32'h0, 32'h0, 32'h0);
      check("slti_src2", alu_src2_o, 32'hFFFFFFFF);
      check("slti_ctrl", {28'd0, alu_ctrl_o}, 32'h7);
      step();
      check("slti_wb_data", wb_data_o, 32'h0);
      check("slti_wb_we", {31'd0, wb_we_o}, 32'd1);
      check("slti_wb_reg", {27'd0, wb_reg_o}, 32'd6);
      step();

      // ---- BEQ taken, backward target ----
      send(itype(6'h04, 5'd2, 16'hFFFE), 32'h100, 32'd5, 32'd5);
      check("beq_ctrl", {28'd0, alu_ctrl_o}, 32'h3);
      step();
      check("beq_branch", {31'd0, branch_o}, 32'd1);
      check("beq_taken", {31'd0, branch_taken_o}, 32'd1);
      check("beq_target", branch_target_o, 32'h000000FC);
      check("beq_wb_we", {31'd0, wb_we_o}, 32'd0);
      step();

      // ---- BNE not taken ----
      send(itype(6'h05, 5'd2, 16'hFFFE), 32'h100, 32'd5, 32'd5);
      check("bne_ctrl", {28'd0, alu_ctrl_o}, 32'h4);
      step();
      check("bne_branch", {31'd0, branch_o}, 32'd1);
      check("bne_taken", {31'd0, branch_taken_o}, 32'd0);
      check("bne_target", branch_target_o, 32'h000000FC);
      step();

      // ---- Backpressure: ADDI held, ORI waiting ----
      rsp_ready_i = 1'b0;
      send(itype(6'h08, 5'd7, 16'h0010), 32'h0, 32'h20, 32'h0);
      step();
      instr_i       = itype(6'h0D, 5'd8, 16'h8000);
      rs_data_i     = 32'h1;
      instr_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
         check("bp_ready", {31'd0, instr_ready_o}, 32'd0);
         check("bp_wb_data", wb_data_o, 32'h30);
         check("bp_wb_reg", {27'd0, wb_reg_o}, 32'd7);
         check("bp_wb_we", {31'd0, wb_we_o}, 32'd1);
         step();
      end
      rsp_ready_i = 1'b1;
      #1;
      check("bp_rise_ready", {31'd0, instr_ready_o}, 32'd0);
      check("bp_rise_valid", {31'd0, rsp_valid_o}, 32'd1);
      step();
      check("bp_idle_ready", {31'd0, instr_ready_o}, 32'd1);
      check("bp_idle_valid", {31'd0, rsp_valid_o}, 32'd0);
      step();
      instr_valid_i = 1'b0;
      check("ori_exec_ready", {31'd0, instr_ready_o}, 32'd0);
      check("ori_ctrl", {28'd0, alu_ctrl_o}, 32'h1);
      check("ori_src2", alu_src2_o, 32'h00008000);
      step();
      check("ori_wb_data", wb_data_o, 32'h00008001);
      check("ori_wb_reg", {27'd0, wb_reg_o}, 32'd8);
      step();

      // ---- Illegal opcode ----
      send({6'h3F, 26'h0}, 32'h0, 32'h1, 32'h2);
      check("ill_ctrl", {28'd0, alu_ctrl_o}, 32'h0);
      step();
      check("ill_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("ill_illegal", {31'd0, illegal_o}, 32'd1);
      check("ill_wb_we", {31'd0, wb_we_o}, 32'd0);
      check("ill_branch", {31'd0, branch_o}, 32'd0);
      step();

      // ---- ADDI to r0 ----
      send(itype(6'h08, 5'd0, 16'h0005), 32'h0, 32'h1, 32'h0);
      step();
      check("r0_wb_we", {31'd0, wb_we_o}, 32'd0);
      check("r0_illegal", {31'd0, illegal_o}, 32'd0);
      check("r0_wb_data", wb_data_o, 32'h6);
      step();
      check("end_ready", {31'd0, instr_ready_o}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
